// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU ports, the arbiter and the unified memory.
//   i_*   : instruction-fetch requester (level request, one-cycle ready pulse)
//   d_*   : data (LW/SW) requester (level request, one-cycle ready pulse)
//   mem_* : single-ported fixed-latency memory side
//   busy  : arbiter has an access in flight
// Modport slave is taken by the arbiter; master is the environment side (CPU + memory).
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ready;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_ready, i_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_ready, i_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory between instruction fetch and data access.
// One access at a time: a winner is picked in IDLE, a single registered mem_en strobe is issued,
// LAT cycles are counted out, then the winner gets a one-cycle ready pulse with read data.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : mem_arbiter_if.slave (fetch port, data port, memory port, busy)
//
// Parameters: ADDR_W, DATA_W, LAT (1..15), STARVE_MAX (1..15).
// Build option: define MEM_ARB_RR_EN for round-robin conflict resolution; otherwise data wins
// conflicts until it has been granted STARVE_MAX times in a row over a waiting fetch.
module mem_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned LAT        = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   localparam logic [3:0] LatCnt = 4'(LAT);

   typedef enum logic {StIdle = 1'b0, StWait = 1'b1} state_e;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              gnt_d_q;   // 1: data port owns the current access
   logic              gnt_we_q;  // current access is a write (no rdata capture)
   logic              i_ready_q;
   logic              d_ready_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              busy_q;
   logic              pick_d;

`ifdef MEM_ARB_RR_EN
   logic              last_d_q;  // most recent grant went to the data port
`else
   localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
   logic [3:0]        starve_q;  // consecutive data grants taken while fetch waited
`endif

   // Only meaningful when at least one request is present; i wins whenever pick_d is 0.
   always_comb begin
      pick_d = 1'b0;
`ifdef MEM_ARB_RR_EN
      pick_d = bus.d_req && (!bus.i_req || !last_d_q);
`else
      pick_d = bus.d_req && (!bus.i_req || (starve_q != StarveMax));
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         gnt_d_q     <= 1'b0;
         gnt_we_q    <= 1'b0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_d_q    <= 1'b0;
`else
         starve_q    <= '0;
`endif
      end else begin
         // Strobes and ready pulses are single-cycle unless re-asserted below.
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         mem_en_q  <= 1'b0;
         mem_we_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.i_req || bus.d_req) begin
                  if (pick_d) begin
                     mem_addr_q  <= bus.d_addr;
                     mem_wdata_q <= bus.d_wdata;
                     mem_we_q    <= bus.d_we;
                     gnt_we_q    <= bus.d_we;
                     gnt_d_q     <= 1'b1;
                  end else begin
                     mem_addr_q  <= bus.i_addr;
                     mem_we_q    <= 1'b0;
                     gnt_we_q    <= 1'b0;
                     gnt_d_q     <= 1'b0;
                  end
`ifdef MEM_ARB_RR_EN
                  last_d_q <= pick_d;
`else
                  if (pick_d && bus.i_req) starve_q <= starve_q + 4'd1;
                  else                     starve_q <= '0;
`endif
                  mem_en_q <= 1'b1;
                  cnt_q    <= LatCnt;
                  busy_q   <= 1'b1;
                  state_q  <= StWait;
               end
            end
            StWait: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  if (gnt_d_q) begin
                     d_ready_q <= 1'b1;
                     if (!gnt_we_q) d_rdata_q <= bus.mem_rdata;
                  end else begin
                     i_ready_q <= 1'b1;
                     i_rdata_q <= bus.mem_rdata;
                  end
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
         endcase
      end
   end

   assign bus.i_ready   = i_ready_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (LAT = 2, STARVE_MAX = 4).
// Expected read data is queued per port when a request is driven and compared on each ready.
module tb_mem_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .LAT       (2),
      .STARVE_MAX(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: read word is a fixed function of the held address.
   function automatic logic [31:0] pat(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   assign bus.mem_rdata = pat(bus.mem_addr);

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   typedef struct packed {
      logic        we;
      logic [31:0] data;
   } d_exp_t;

   logic [31:0] i_q[$];
   d_exp_t      d_q[$];
   logic [7:0]  order[$];
   logic [31:0] d_last = '0;
   int          we_cnt = 0;
   int          i_ready_cnt = 0;
   logic [31:0] we_addr = '0;
   logic [31:0] we_data = '0;

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      logic [31:0] e;
      d_exp_t      de;
      if (!rst) d_last = '0;
      if (bus.i_ready && bus.d_ready) check("ready_overlap", 32'(1), 32'(0));
      if (bus.mem_we && !bus.mem_en)  check("we_without_en", 32'(1), 32'(0));
      if (bus.mem_en && bus.mem_we) begin
         we_cnt++;
         we_addr = bus.mem_addr;
         we_data = bus.mem_wdata;
      end
      if (bus.i_ready) begin
         i_ready_cnt++;
         order.push_back("i");
         if (i_q.size() == 0) check("i_spurious_ready", 32'(1), 32'(0));
         else begin
            e = i_q.pop_front();
            check("i_rdata", bus.i_rdata, e);
         end
      end
      if (bus.d_ready) begin
         order.push_back("d");
         if (d_q.size() == 0) check("d_spurious_ready", 32'(1), 32'(0));
         else begin
            de = d_q.pop_front();
            e  = de.we ? d_last : de.data;
            if (!de.we) d_last = de.data;
            check("d_rdata", bus.d_rdata, e);
         end
      end
   end

   // Waits for one port's ready (bounded), drops its request, reports edges since E0 (-1 = timeout).
   task automatic wait_ready(input bit is_d, output int lat);
      int c0;
      c0  = cyc;
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (is_d ? bus.d_ready : bus.i_ready) begin
            lat = cyc - c0 - 1;
            if (is_d) bus.d_req = 1'b0;
            else      bus.i_req = 1'b0;
            return;
         end
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_busy"},      32'(bus.busy),    0);
      check({tag, "_mem_en"},    32'(bus.mem_en),  0);
      check({tag, "_mem_we"},    32'(bus.mem_we),  0);
      check({tag, "_mem_addr"},  bus.mem_addr,     0);
      check({tag, "_mem_wdata"}, bus.mem_wdata,    0);
      check({tag, "_i_rdata"},   bus.i_rdata,      0);
      check({tag, "_d_rdata"},   bus.d_rdata,      0);
      check({tag, "_i_ready"},   32'(bus.i_ready), 0);
      check({tag, "_d_ready"},   32'(bus.d_ready), 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int     lat;
      int     d_lat;
      int     i_lat;
      int     c0;
      int     dn;
      int     in;
      int     n_d;
      int     n_i;
      int     snap;
      string  exp_order;

      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check_cleared("reset");
      rst = 1'b1;

      // Single fetch
      @(negedge clk);
      bus.i_addr = 32'h40;
      bus.i_req  = 1'b1;
      i_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      check("fetch_mem_en",   32'(bus.mem_en), 1);
      check("fetch_mem_addr", bus.mem_addr,    32'h40);
      check("fetch_mem_we",   32'(bus.mem_we), 0);
      check("fetch_busy1",    32'(bus.busy),   1);
      @(negedge clk);
      check("fetch_mem_en_drop", 32'(bus.mem_en),  0);
      check("fetch_busy2",       32'(bus.busy),    1);
      check("fetch_no_ready",    32'(bus.i_ready), 0);
      @(negedge clk);
      check("fetch_ready", 32'(bus.i_ready), 1);
      check("fetch_busy3", 32'(bus.busy),    0);
      bus.i_req = 1'b0;
      @(negedge clk);
      check("fetch_ready_pulse", 32'(bus.i_ready), 0);
      check("fetch_rdata_held",  bus.i_rdata,      32'hDEADBEEF);

      // Conflict: data wins, fetch issued right after the data ready cycle
      @(negedge clk);
      bus.i_addr = 32'h44;
      bus.d_addr = 32'h80;
      bus.d_we   = 1'b0;
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      i_q.push_back(pat(32'h44));
      d_q.push_back('{we: 1'b0, data: pat(32'h80)});
      order.delete();
      c0    = cyc;
      d_lat = -1;
      i_lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.d_ready && d_lat < 0) begin
            d_lat     = cyc - c0 - 1;
            bus.d_req = 1'b0;
         end
         if (bus.i_ready && i_lat < 0) begin
            i_lat     = cyc - c0 - 1;
            bus.i_req = 1'b0;
         end
         if (d_lat >= 0 && i_lat >= 0) break;
      end
      @(negedge clk);
      check("conflict_d_lat", d_lat, 2);
      check("conflict_i_lat", i_lat, 5);
      check("conflict_first", 32'((order.size() > 0) ? order[0] : 8'h3F), 32'("d"));

      // Write
      @(negedge clk);
      bus.d_addr  = 32'h100;
      bus.d_wdata = 32'h12345678;
      bus.d_we    = 1'b1;
      bus.d_req   = 1'b1;
      d_q.push_back('{we: 1'b1, data: '0});
      we_cnt = 0;
      snap   = i_ready_cnt;
      wait_ready(1'b1, lat);
      bus.d_we = 1'b0;
      @(negedge clk);
      check("write_lat",       lat,          2);
      check("write_we_cycles", we_cnt,       1);
      check("write_addr",      we_addr,      32'h100);
      check("write_data",      we_data,      32'h12345678);
      check("write_d_rdata",   bus.d_rdata,  pat(32'h80));
      check("write_no_i",      i_ready_cnt,  snap);

      // Arbitration under continuous requests, from a fresh reset
      pulse_reset();
`ifdef MEM_ARB_RR_EN
      n_d       = 2;
      n_i       = 2;
      exp_order = "didi";
`else
      n_d       = 5;
      n_i       = 1;
      exp_order = "ddddid";
`endif
      @(negedge clk);
      bus.i_addr = 32'h48;
      bus.d_addr = 32'h84;
      for (int k = 0; k < n_d; k++) d_q.push_back('{we: 1'b0, data: pat(32'h84)});
      for (int k = 0; k < n_i; k++) i_q.push_back(pat(32'h48));
      order.delete();
      bus.i_req = 1'b1;
      bus.d_req = 1'b1;
      dn = 0;
      in = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.d_ready) begin
            dn++;
            if (dn == n_d) bus.d_req = 1'b0;
         end
         if (bus.i_ready) begin
            in++;
            if (in == n_i) bus.i_req = 1'b0;
         end
         if (dn >= n_d && in >= n_i) break;
      end
      @(negedge clk);
      check("arb_grant_count", order.size(), exp_order.len());
      for (int k = 0; k < exp_order.len(); k++)
         check($sformatf("arb_grant%0d", k),
               32'((k < order.size()) ? order[k] : 8'h3F), 32'(exp_order[k]));

      // Reset mid-access: everything clears at once, the dropped access never completes
      @(negedge clk);
      bus.i_addr = 32'h4C;
      bus.i_req  = 1'b1;
      @(negedge clk);
      check("mid_busy_before",   32'(bus.busy),   1);
      check("mid_mem_en_before", 32'(bus.mem_en), 1);
      rst       = 1'b0;
      bus.i_req = 1'b0;
      #1;
      check_cleared("mid_reset");
      repeat (2) @(negedge clk);
      rst  = 1'b1;
      snap = i_ready_cnt;
      repeat (5) @(negedge clk);
      check("mid_no_ready", i_ready_cnt, snap);
      bus.i_req = 1'b1;
      i_q.push_back(pat(32'h4C));
      wait_ready(1'b0, lat);
      check("post_reset_lat", lat, 2);
      @(negedge clk);

      check("i_q_drained", i_q.size(), 0);
      check("d_q_drained", d_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port and its data (LW/SW) port. Each requester holds a level request; the arbiter picks a winner, issues one registered memory access, counts out the memory latency and returns a one-cycle ready pulse with read data to the winner. It sits between the CPU's fetch/MEM stages and the memory array, and its ready pulses drive the CPU's stall logic.

## Interface
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits
- LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- STARVE_MAX, 4, consecutive data grants allowed while i_req is pending; legal range 1..15

- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock; reset is asynchronous and active-low
- i_req  in  1  fetch request, held until i_ready
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  one-cycle completion pulse for fetch
- i_rdata  out  DATA_W  fetched word, held until the next fetch completion
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = write, 0 = read; sampled with d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ready  out  1  one-cycle completion pulse for data
- d_rdata  out  DATA_W  loaded word, held until the next data read completion
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write strobe, only together with mem_en
- mem_addr  out  ADDR_W  memory address, byte address passed through unchanged
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid LAT cycles after mem_en
- busy  out  1  1 whenever state is not IDLE

## Operation
- States: IDLE, WAIT.
- IDLE, no request: remain in IDLE with all strobes 0.
- IDLE, any request at a clock edge: select the winner, register mem_addr, mem_wdata and mem_we (data port: d_we; fetch port: 0), set mem_en to 1, load the counter with LAT, record the winner in gnt, and enter WAIT.
- WAIT: mem_en and mem_we drop to 0 after the first cycle. The counter decrements every edge.
- At the edge where the counter goes from 1 to 0, the arbiter:
  - captures mem_rdata into the winner's rdata register (reads only; writes leave d_rdata unchanged),
  - pulses the winner's ready for one cycle,
  - returns to IDLE.
- A requester drops req during its ready cycle. A req still high at the next edge is treated as a new request.
- Selection (default): d wins a conflict unless starve_cnt == STARVE_MAX, in which case i wins.
  - starve_cnt increments on a d grant while i_req = 1.
  - starve_cnt clears on any i grant, and on a d grant with i_req = 0.
  - A lone requester always wins.
- mem_addr and mem_wdata hold their last values between accesses.
- i_ready and d_ready are never high in the same cycle.

## Timing
- Request sampled at edge E0 → mem_en = 1 in cycle E0..E0+1 → ready = 1 in cycle E0+LAT..E0+LAT+1.
- Request-to-ready latency is LAT edges. Back-to-back throughput is one access per LAT+1 cycles.
- The losing requester is issued at the edge right after the winner's ready cycle.
- Reset (rst = 0), asynchronous and effective in any state:
  - state returns to IDLE, counter and starve_cnt clear,
  - all outputs clear to 0: i_rdata and d_rdata 0, mem_en, mem_we, ready pulses and busy 0, mem_addr and mem_wdata 0,
  - any in-flight access is dropped; no ready pulse is ever produced for it.
- After rst rises, the first edge with a req set starts a fresh access.
- LAT = 1: WAIT lasts one cycle; ready is high in cycle E0+1..E0+2.

## Configuration
- MEM_ARB_RR_EN defined: conflicts are resolved round-robin. The port not granted most recently wins; after reset, d has priority. starve_cnt and STARVE_MAX are unused.
- MEM_ARB_RR_EN undefined: data-priority selection with the starvation counter, as described in Operation.

## Test plan
- Single fetch:
  - Stimulus: LAT = 2, i_req with i_addr = 0x40, memory returns 0xDEADBEEF.
  - Response: mem_en = 1 with mem_addr = 0x40 and mem_we = 0 for one cycle after E0; i_ready pulses after E0+2 with i_rdata = 0xDEADBEEF; busy = 1 for 2 cycles.
- Conflict:
  - Stimulus: i_req and d_req (read 0x80) both rise before E0.
  - Response: d issued at E0, d_ready at E0+2; i issued at E0+3, i_ready at E0+5.
- Starvation:
  - Stimulus: i_req held; d_req re-raised immediately after every d_ready; STARVE_MAX = 4.
  - Response: grants are d, d, d, d, then i; after that, d again.
- Write:
  - Stimulus: d_we = 1, d_addr = 0x100, d_wdata = 0x12345678.
  - Response: mem_en = mem_we = 1 for exactly one cycle with those address/data values; d_ready after E0+2; d_rdata unchanged; i_ready stays 0.
- Reset mid-access:
  - Stimulus: drop rst one cycle after E0.
  - Response: busy, mem_en and mem_we go to 0 immediately, rdata registers go to 0, and no ready pulse appears. After release, a new i_req completes in LAT edges.
- MEM_ARB_RR_EN build:
  - Stimulus: both ports re-request continuously.
  - Response: grants alternate d, i, d, i.
